// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LED_OFF   = 2'd0,
    LED_SOLID = 2'd1,
    LED_BLINK = 2'd2,
    LED_CHASE = 2'd3
  } led_mode_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } led_state_e;

endpackage

// File: rtl/led_sequencer_if.sv
// Control/indicator bundle between upstream logic and the LED sequencer.
interface led_sequencer_if #(
  parameter int unsigned LED_NUMBER = 10
);
  import led_pkg::*;

  logic                  ready;
  logic [MODE_W-1:0]     mode;
  logic [LED_NUMBER-1:0] leds;
  logic                  busy;

  modport master (output ready, output mode, input leds, input busy);
  modport slave  (input ready, input mode, output leds, output busy);

endinterface

// File: rtl/led_tick_gen.sv
// Pattern tick prescaler: one-cycle tick every TICK_DIV clocks, synchronous clear.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: OFF/SOLID/BLINK/CHASE with bounded, retriggerable duration.
// Define LED_SEQ_BOUNCE_EN to make CHASE ping-pong instead of wrapping.
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned LED_NUMBER     = 10,
  parameter int unsigned TICK_DIV       = 25_000_000,
  parameter int unsigned CNT_W          = 25,
  parameter int unsigned DURATION_TICKS = 8,
  parameter int unsigned DUR_W          = 8
) (
  input  logic            clk,
  input  logic            rst,
  led_sequencer_if.slave  bus
);

  localparam int unsigned LW         = LED_NUMBER;
  localparam bit          TIMEOUT_EN = (DURATION_TICKS != 0);

  led_state_e       state_q, state_d;
  led_mode_e        mode_q, mode_d;
  logic [LW-1:0]    leds_q, leds_d;
  logic             busy_q, busy_d;
  logic [DUR_W-1:0] ticks_q, ticks_d;
  logic             tick;
  logic             clr_tick;
  led_mode_e        req_mode;
  logic [LW-1:0]    init_pat;
`ifdef LED_SEQ_BOUNCE_EN
  logic             dir_q, dir_d;  // 0 = shifting left, 1 = shifting right
`endif

  assign req_mode = led_mode_e'(bus.mode);
  assign init_pat = (req_mode == LED_CHASE) ? LW'(1) : '1;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_tick),
    .tick (tick)
  );

  // Next-state, pattern and duration logic; ready has priority over tick/timeout.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    leds_d   = leds_q;
    ticks_d  = ticks_q;
    clr_tick = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
    dir_d    = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        leds_d   = '0;
        ticks_d  = '0;
        clr_tick = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
        dir_d    = 1'b0;
`endif
        if (bus.ready && req_mode != LED_OFF) begin
          state_d = S_ACTIVE;
          mode_d  = req_mode;
          leds_d  = init_pat;
        end
      end
      S_ACTIVE: begin
        if (bus.ready) begin
          clr_tick = 1'b1;
          ticks_d  = '0;
`ifdef LED_SEQ_BOUNCE_EN
          dir_d    = 1'b0;
`endif
          if (req_mode == LED_OFF) begin
            state_d = S_IDLE;
            leds_d  = '0;
          end else begin
            mode_d = req_mode;
            leds_d = init_pat;
          end
        end else if (tick) begin
          ticks_d = ticks_q + DUR_W'(1);
          if (TIMEOUT_EN && ticks_d == DUR_W'(DURATION_TICKS)) begin
            state_d = S_IDLE;
            leds_d  = '0;
            ticks_d = '0;
          end else begin
            case (mode_q)
              LED_BLINK: leds_d = ~leds_q;
              LED_CHASE: begin
`ifdef LED_SEQ_BOUNCE_EN
                if (!dir_q) begin
                  if (leds_q[LW-1]) begin
                    dir_d  = 1'b1;
                    leds_d = leds_q >> 1;
                  end else begin
                    leds_d = leds_q << 1;
                  end
                end else begin
                  if (leds_q[0]) begin
                    dir_d  = 1'b0;
                    leds_d = leds_q << 1;
                  end else begin
                    leds_d = leds_q >> 1;
                  end
                end
`else
                leds_d = {leds_q[LW-2:0], leds_q[LW-1]};
`endif
              end
              default: leds_d = leds_q;
            endcase
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        leds_d  = '0;
      end
    endcase
    busy_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= LED_OFF;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      ticks_q <= '0;
`ifdef LED_SEQ_BOUNCE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      ticks_q <= ticks_d;
`ifdef LED_SEQ_BOUNCE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign bus.leds = leds_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: four instances (duration 4, 6, unlimited, TICK_DIV=1).
module tb_led_sequencer;
  import led_pkg::*;

  typedef struct {
    logic       r;
    logic [1:0] m;
    logic [3:0] l;
    logic       b;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       ready;
  logic [1:0] mode;
  int         n_checks;
  int         n_fail;
  vec_t       vt[$];

  led_sequencer_if #(.LED_NUMBER(4)) if4 ();
  led_sequencer_if #(.LED_NUMBER(4)) if6 ();
  led_sequencer_if #(.LED_NUMBER(4)) if0 ();
  led_sequencer_if #(.LED_NUMBER(4)) if1 ();

  assign if4.ready = ready;
  assign if4.mode  = mode;
  assign if6.ready = ready;
  assign if6.mode  = mode;
  assign if0.ready = ready;
  assign if0.mode  = mode;
  assign if1.ready = ready;
  assign if1.mode  = mode;

  led_sequencer #(.LED_NUMBER(4), .TICK_DIV(3), .CNT_W(2), .DURATION_TICKS(4), .DUR_W(8))
    u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  led_sequencer #(.LED_NUMBER(4), .TICK_DIV(3), .CNT_W(2), .DURATION_TICKS(6), .DUR_W(8))
    u_dut6 (.clk(clk), .rst(rst), .bus(if6));
  led_sequencer #(.LED_NUMBER(4), .TICK_DIV(3), .CNT_W(2), .DURATION_TICKS(0), .DUR_W(8))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  led_sequencer #(.LED_NUMBER(4), .TICK_DIV(1), .CNT_W(1), .DURATION_TICKS(2), .DUR_W(8))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [3:0] al, input logic [3:0] el,
                       input logic ab, input logic eb);
    n_checks++;
    if (al !== el || ab !== eb) begin
      n_fail++;
      $display("FAIL %s[%0d]: leds=%b busy=%b, expected leds=%b busy=%b", name, idx, al, ab, el, eb);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] m);
    @(negedge clk);
    ready = r;
    mode  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [1:0] m, input logic [3:0] l, input logic b, input int n);
    vec_t v;
    v.r = r; v.m = m; v.l = l; v.b = b;
    repeat (n) vt.push_back(v);
  endtask

  initial begin
    logic [3:0] el;
    logic       eb;
    int         p;
    n_checks = 0;
    n_fail   = 0;
    ready    = 1'b0;
    mode     = 2'd0;
    rst      = 1'b0;

    // Duration-4 instance: SOLID, OFF-in-idle, CHASE, BLINK retriggered on a tick, BLINK cancelled
    add(1, LED_SOLID, 4'b1111, 1, 1);  add(0, LED_OFF, 4'b1111, 1, 11); add(0, LED_OFF, 4'b0000, 0, 2);
    add(1, LED_OFF,   4'b0000, 0, 1);
    add(1, LED_CHASE, 4'b0001, 1, 1);  add(0, LED_OFF, 4'b0001, 1, 2);
    add(0, LED_OFF,   4'b0010, 1, 3);  add(0, LED_OFF, 4'b0100, 1, 3);
    add(0, LED_OFF,   4'b1000, 1, 3);  add(0, LED_OFF, 4'b0000, 0, 2);
    add(1, LED_BLINK, 4'b1111, 1, 1);  add(0, LED_OFF, 4'b1111, 1, 2);
    add(0, LED_OFF,   4'b0000, 1, 3);  add(0, LED_OFF, 4'b1111, 1, 3);
    add(1, LED_SOLID, 4'b1111, 1, 1);  add(0, LED_OFF, 4'b1111, 1, 11); add(0, LED_OFF, 4'b0000, 0, 1);
    add(1, LED_BLINK, 4'b1111, 1, 1);  add(0, LED_OFF, 4'b1111, 1, 1);
    add(1, LED_OFF,   4'b0000, 0, 1);  add(0, LED_OFF, 4'b0000, 0, 2);

    repeat (2) @(posedge clk);
    #1;
    check("reset_d4", 0, if4.leds, 4'b0000, if4.busy, 1'b0);
    check("reset_d6", 0, if6.leds, 4'b0000, if6.busy, 1'b0);
    check("reset_d0", 0, if0.leds, 4'b0000, if0.busy, 1'b0);
    check("reset_t1", 0, if1.leds, 4'b0000, if1.busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].m);
      check("table", i, if4.leds, vt[i].l, if4.busy, vt[i].b);
    end

    // Asynchronous reset in the middle of BLINK, then quiet until the next ready
    step(1'b1, LED_BLINK);
    step(1'b0, LED_OFF);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_d4", 0, if4.leds, 4'b0000, if4.busy, 1'b0);
    check("async_rst_d0", 0, if0.leds, 4'b0000, if0.busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, LED_OFF);
      check("post_rst_idle", k, if0.leds, 4'b0000, if0.busy, 1'b0);
    end

    // CHASE wraps on the duration-6 instance; TICK_DIV=1 instance steps every cycle
    for (int k = 0; k <= 18; k++) begin
      step(k == 0, (k == 0) ? LED_CHASE : LED_OFF);
      el = (k < 18) ? 4'(4'b0001 << ((k / 3) % 4)) : 4'b0000;
      check("chase_d6", k, if6.leds, el, if6.busy, k < 18);
      if (k <= 4) begin
        el = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : 4'b0000;
        check("chase_t1", k, if1.leds, el, if1.busy, k < 2);
      end
    end

    // Unlimited-duration CHASE
    for (int k = 0; k < 24; k++) begin
      step(k == 0, (k == 0) ? LED_CHASE : LED_OFF);
`ifdef LED_SEQ_BOUNCE_EN
      p = (k / 3) % 6;
      if (p > 3) p = 6 - p;
`else
      p = (k / 3) % 4;
`endif
      el = 4'(4'b0001 << p);
      check("chase_d0", k, if0.leds, el, if0.busy, 1'b1);
    end

    // Unlimited-duration BLINK keeps busy high; TICK_DIV=1 BLINK times out after two ticks
    for (int k = 0; k < 36; k++) begin
      step(k == 0, (k == 0) ? LED_BLINK : LED_OFF);
      el = (((k / 3) % 2) == 0) ? 4'b1111 : 4'b0000;
      check("blink_d0", k, if0.leds, el, if0.busy, 1'b1);
      if (k <= 3) begin
        el = (k == 0) ? 4'b1111 : 4'b0000;
        eb = (k < 2);
        check("blink_t1", k, if1.leds, el, if1.busy, eb);
      end
    end
    step(1'b1, LED_OFF);
    check("cancel_d0", 0, if0.leds, 4'b0000, if0.busy, 1'b0);
    step(1'b0, LED_OFF);
    check("cancel_d0", 1, if0.leds, 4'b0000, if0.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer for the status/indicator path. It is the successor to the single-pattern LED driver and drives `LED_NUMBER` LEDs with four selectable patterns: off, solid, blink and chase. Patterns are timed by an internal tick prescaler and last for a bounded, retriggerable duration. A `ready` pulse from upstream logic starts or replaces the pattern. The block sits between control logic and the board LED pins.

## Interface
- `LED_NUMBER`, 10, number of LEDs driven; must be ≥ 2.
- `TICK_DIV`, 25_000_000, clock cycles per pattern tick; must be ≥ 1.
- `CNT_W`, 25, prescaler counter width; must hold `TICK_DIV-1`.
- `DURATION_TICKS`, 8, pattern length in ticks; 0 means run until cancelled.
- `DUR_W`, 8, duration counter width; must hold `DURATION_TICKS`.

Ports:
- `clk` input 1 — system clock, rising edge.
- `rst` input 1 — reset; one clock; reset is asynchronous and active-low.
- `ready` input 1 — start/retrigger strobe, sampled on rising `clk`.
- `mode` input 2 — pattern, sampled with `ready`: 0 OFF, 1 SOLID, 2 BLINK, 3 CHASE.
- `leds` output `LED_NUMBER` — registered LED drive, 1 = lit.
- `busy` output 1 — high while a pattern is active.

## Operation
- FSM has two states: IDLE and ACTIVE.
- IDLE:
  - `leds`=0 and `busy`=0.
  - `ready`=1 with `mode`≠OFF → ACTIVE: latch `mode`, clear the prescaler and tick count, load the initial pattern.
  - `ready` with `mode`=OFF → stays IDLE.
- ACTIVE:
  - `ready` with `mode`≠OFF retriggers: new mode latched, counters cleared, initial pattern reloaded.
  - `ready` with `mode`=OFF cancels → IDLE, `leds`=0.
  - Otherwise the pattern advances on each tick.
- Initial patterns and per-tick update:
  - SOLID: all ones; unchanged on tick.
  - BLINK: all ones; whole vector inverts on each tick.
  - CHASE: one-hot, bit 0 set; rotates left one position per tick, so bit `LED_NUMBER-1` wraps to bit 0.
- Tick generation:
  - Prescaler counts 0..`TICK_DIV-1`.
  - The tick is a one-cycle pulse when the count equals `TICK_DIV-1`; the count then returns to 0.
  - With `TICK_DIV`=1 a tick occurs every cycle.
- Duration:
  - The tick counter increments on each tick.
  - The tick that makes the count equal `DURATION_TICKS` returns the FSM to IDLE with `leds`=0; no pattern advance happens on that tick.
  - `DURATION_TICKS`=0 disables the timeout.
- Simultaneous events: `ready` wins over a tick and over timeout in the same cycle.
- Reset mid-operation: all state clears immediately, asynchronously, regardless of phase.

## Timing
- Reset values: `leds`=0, `busy`=0, FSM=IDLE, all counters 0.
- Start latency: `ready` sampled at edge N → `leds` and `busy` valid after edge N; one-cycle latency.
- First tick occurs `TICK_DIV` cycles after the start edge.
- Pattern changes are visible after the same edge that produced the tick.
- Active time per trigger is exactly `TICK_DIV*DURATION_TICKS` cycles from the start edge to the `busy` fall edge.
- `leds` and `busy` are registered; no combinational path from the inputs.

## Configuration
- Macro: `LED_SEQ_BOUNCE_EN`.
- Defined: CHASE ping-pongs.
  - It shifts left until bit `LED_NUMBER-1`, then right until bit 0, then left again.
  - The end bits are not repeated at each reversal.
  - A direction register is added, reset to left, and reset to left on every start or retrigger.
- Undefined: CHASE rotates with wrap as described above; no direction register exists.

## Structure
- Package `led_pkg` holds:
  - the mode enum: `LED_OFF`, `LED_SOLID`, `LED_BLINK`, `LED_CHASE`;
  - the FSM state enum: `S_IDLE`, `S_ACTIVE`;
  - the mode-width constant (2).
- Sub-module `led_tick_gen` is the prescaler.
  - Parameters: `TICK_DIV`, `CNT_W`.
  - Ports: `clk`, `rst`, `clr`, `tick`.
  - `clr` synchronously zeroes the count.
- Pattern logic, the FSM and the duration counter stay in `led_sequencer`.

## Test plan
Bench parameters: `LED_NUMBER`=4, `TICK_DIV`=3, `DURATION_TICKS`=4 unless stated.
- Reset asserted mid-BLINK → `leds`=4'b0000 and `busy`=0 immediately; after release, no activity until `ready`.
- `ready`, SOLID → 4'b1111 the next cycle, held 12 cycles, then 4'b0000 and `busy`=0.
- `ready`, CHASE → 0001, 0010, 0100, 1000 at 3-cycle steps, then IDLE; with `DURATION_TICKS`=6: 0001, 0010, 0100, 1000, 0001, 0010, showing the wrap.
- `LED_SEQ_BOUNCE_EN` defined, CHASE, `DURATION_TICKS`=0 → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- BLINK started, then `ready`+SOLID on the same cycle as a tick → 1111 and counters cleared; then `ready`+OFF → 0000 the next cycle.
- `DURATION_TICKS`=0, BLINK → alternates 1111/0000 every 3 cycles for more than 30 cycles with `busy` held high.
